bicubic_line_sched: RTL

- Controller for the 4-bank interleaved 24-bit line buffer used by the bicubic scaler. The buffer holds up to 2048 pixels: 4 banks of 512, bank chosen by address bits [1:0].
- Per line, the block first writes SRC_W incoming pixels into the buffer (FILL). It then issues DST_W 4-tap horizontal reads at fixed-point positions (READ) and tags returning taps with valid, fractional phase and last-of-line.
- Sits between the pixel input stream and the buffer; its tap outputs feed the bicubic weight/MAC stage.

---
 rtl/bicubic_pkg.sv | 19 +
 rtl/tap_latency_pipe.sv | 35 +++
 rtl/bicubic_line_sched.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/bicubic_pkg.sv
// Shared types and helpers for the bicubic scaler line scheduler.
package bicubic_pkg;

  localparam int FRAC_DEF          = 8;
  localparam int ADDRESS_WIDTH_DEF = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic logic [31:0] clamp_max(input logic [31:0] v, input logic [31:0] hi);
    return (v > hi) ? hi : v;
  endfunction

endpackage

// File: rtl/tap_latency_pipe.sv
// Fixed-depth shift register tagging buffer read data with {frac, last}; flushed by rst.
module tap_latency_pipe #(
  parameter int RD_LAT = 5,
  parameter int WIDTH  = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] payload_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] payload_o
);

  logic [RD_LAT-1:0] vld_q;
  logic [WIDTH-1:0]  pay_q [RD_LAT];

  // Payload is zeroed when not valid so tap_frac/tap_last only show with tap_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) pay_q[i] <= '0;
    end else begin
      vld_q[0] <= vld_i;
      pay_q[0] <= vld_i ? payload_i : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        pay_q[i] <= pay_q[i-1];
      end
    end
  end

  assign vld_o     = vld_q[RD_LAT-1];
  assign payload_o = pay_q[RD_LAT-1];

endmodule

// File: rtl/bicubic_line_sched.sv
// Line scheduler for the bicubic scaler: fills the 4-bank line buffer, then issues
// clamped 4-tap reads at fixed-point source positions and tags the returning taps.
module bicubic_line_sched
  import bicubic_pkg::*;
#(
  parameter int DATA_WIDTH    = 24,
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int FRAC          = FRAC_DEF,
  parameter int RD_LAT        = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDRESS_WIDTH-1:0]      src_width,
  input  logic [ADDRESS_WIDTH-1:0]      dst_width,
  input  logic [ADDRESS_WIDTH+FRAC-1:0] step,
  input  logic                          pix_valid,
  input  logic [DATA_WIDTH-1:0]         pix_data,
  output logic                          pix_ready,
  output logic                          buf_we,
  output logic [DATA_WIDTH-1:0]         buf_data,
  output logic [ADDRESS_WIDTH-1:0]      buf_addrA,
  output logic [ADDRESS_WIDTH-1:0]      buf_addrB,
  output logic [ADDRESS_WIDTH-1:0]      buf_addrC,
  output logic [ADDRESS_WIDTH-1:0]      buf_addrD,
  output logic                          tap_valid,
  output logic [FRAC-1:0]               tap_frac,
  output logic                          tap_last,
  output logic                          busy,
  output logic                          done
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int PW = ADDRESS_WIDTH + FRAC;
  localparam logic [AW-1:0] ONE = AW'(1);

  state_e          state_q, state_d;
  logic [AW-1:0]   src_w_q, dst_w_q, wr_cnt_q, rd_cnt_q, src_max;
  logic [PW-1:0]   step_q, pos_q, pos_d;
  logic [PW:0]     pos_sum;
  logic [AW-1:0]   x0_raw, x0, addr_a, addr_c, addr_d;
  logic [FRAC-1:0] frac, iss_frac_q;
  logic            x0_clamped, wr_fire, rd_fire, rd_last;
  logic            iss_vld_q, iss_last_q;
  logic [FRAC:0]   tap_payload;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (src_width == '0 || dst_width == '0) ? ST_DONE : ST_FILL;
      ST_FILL:  if (wr_fire && wr_cnt_q == src_max) state_d = ST_READ;
      ST_READ:  if (rd_last) state_d = ST_DRAIN;
      ST_DRAIN: if (tap_valid && tap_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pix_ready = (state_q == ST_FILL);
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    wr_fire   = pix_ready & pix_valid;
    rd_fire   = (state_q == ST_READ);
    rd_last   = rd_fire && (rd_cnt_q == dst_w_q - ONE);
  end

  // Tap addresses: x0 clamped to the last source pixel, neighbours clamped to the line edges
  always_comb begin
    src_max    = src_w_q - ONE;
    x0_raw     = pos_q[PW-1:FRAC];
    x0_clamped = (x0_raw > src_max);
    x0         = AW'(clamp_max(32'(x0_raw), 32'(src_max)));
    frac       = x0_clamped ? '0 : pos_q[FRAC-1:0];
    addr_a     = (x0 == '0) ? '0 : x0 - ONE;
    addr_c     = AW'(clamp_max(32'(x0) + 32'd1, 32'(src_max)));
    addr_d     = AW'(clamp_max(32'(x0) + 32'd2, 32'(src_max)));
    pos_sum    = {1'b0, pos_q} + {1'b0, step_q};
    pos_d      = pos_sum[PW] ? '1 : pos_sum[PW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_w_q    <= '0;
      dst_w_q    <= '0;
      step_q     <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      pos_q      <= '0;
      buf_we     <= 1'b0;
      buf_data   <= '0;
      buf_addrA  <= '0;
      buf_addrB  <= '0;
      buf_addrC  <= '0;
      buf_addrD  <= '0;
      iss_vld_q  <= 1'b0;
      iss_frac_q <= '0;
      iss_last_q <= 1'b0;
    end else begin
      buf_we     <= 1'b0;
      iss_vld_q  <= 1'b0;
      iss_last_q <= 1'b0;
      if (state_q == ST_IDLE && start) begin
        src_w_q  <= src_width;
        dst_w_q  <= dst_width;
        step_q   <= step;
        wr_cnt_q <= '0;
        rd_cnt_q <= '0;
        pos_q    <= '0;
      end
      if (wr_fire) begin
        buf_we    <= 1'b1;
        buf_data  <= pix_data;
        buf_addrB <= wr_cnt_q;
        wr_cnt_q  <= wr_cnt_q + ONE;
      end
      if (rd_fire) begin
        buf_addrA  <= addr_a;
        buf_addrB  <= x0;
        buf_addrC  <= addr_c;
        buf_addrD  <= addr_d;
        iss_vld_q  <= 1'b1;
        iss_frac_q <= frac;
        iss_last_q <= rd_last;
        pos_q      <= pos_d;
        rd_cnt_q   <= rd_cnt_q + ONE;
      end
    end
  end

  tap_latency_pipe #(
    .RD_LAT (RD_LAT),
    .WIDTH  (FRAC + 1)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .vld_i     (iss_vld_q),
    .payload_i ({iss_frac_q, iss_last_q}),
    .vld_o     (tap_valid),
    .payload_o (tap_payload)
  );

  assign tap_frac = tap_payload[FRAC:1];
  assign tap_last = tap_payload[0];

endmodule
